// File: rtl/axis_test_pkg.sv
// rtl/axis_test_pkg.sv - shared state encoding and keep helpers for the AXIS test sequencer
package axis_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Widest keep vector the popcount helper accepts (512-bit data bus).
  localparam int MAX_KEEP_W = 64;
  localparam int POP_W      = 7;

  function automatic int keep_width(input int data_width);
    return data_width / 8;
  endfunction

  // Number of enabled bytes in a beat; callers zero-extend narrower keep vectors.
  function automatic logic [POP_W-1:0] keep_popcount(input logic [MAX_KEEP_W-1:0] keep);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      n = n + POP_W'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_rx_byte_accum.sv
// rtl/axis_rx_byte_accum.sv - RX byte accumulator, tlast tracking and length compare
module axis_rx_byte_accum
  import axis_test_pkg::*;
#(
  parameter int KEEP_W    = 8,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 active,
  input  logic                 rx_axis_tvalid,
  input  logic                 rx_axis_tready,
  input  logic                 rx_axis_tlast,
  input  logic [KEEP_W-1:0]    rx_axis_tkeep,
  input  logic [LEN_WIDTH-1:0] expected_len,
  output logic                 rx_seen,
  output logic                 pkt_done,
  output logic                 len_mismatch
);

  // One spare bit so an overlong packet saturates above any legal length.
  localparam int ACC_W = LEN_WIDTH + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic             rx_hs;
  logic [POP_W-1:0] beat_bytes;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // Running total including the current beat, so the tlast beat is part of the compare.
  always_comb begin
    rx_hs        = active && rx_axis_tvalid && rx_axis_tready;
    beat_bytes   = keep_popcount(MAX_KEEP_W'(rx_axis_tkeep));
    sum          = {1'b0, acc} + SUM_W'(beat_bytes);
    acc_sum      = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
    pkt_done     = rx_hs && rx_axis_tlast;
    len_mismatch = pkt_done && (acc_sum != {1'b0, expected_len});
  end

  // Accumulator and rx_seen are reset per packet by the LOAD state.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc     <= '0;
      rx_seen <= 1'b0;
    end else if (rx_hs) begin
      acc <= acc_sum;
      if (rx_axis_tlast) begin
        rx_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_test_sequencer.sv
// rtl/axis_test_sequencer.sv - per-packet sequencer for the AXIS TX generator / RX checker pair
module axis_test_sequencer
  import axis_test_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int LEN_WIDTH       = 16,
  parameter int CNT_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES  = 65535,
  localparam int KEEP_W         = keep_width(AXIS_DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_num,
  input  logic [LEN_WIDTH-1:0] cfg_len_min,
  input  logic [LEN_WIDTH-1:0] cfg_len_max,
  input  logic [15:0]          cfg_gap,
  output logic                 test_en,
  output logic [LEN_WIDTH-1:0] tx_size,
  input  logic                 tx_axis_tvalid,
  input  logic                 tx_axis_tready,
  input  logic                 tx_axis_tlast,
  input  logic                 rx_axis_tvalid,
  input  logic                 rx_axis_tready,
  input  logic                 rx_axis_tlast,
  input  logic [KEEP_W-1:0]    rx_axis_tkeep,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [CNT_WIDTH-1:0] tx_pkt_cnt,
  output logic [CNT_WIDTH-1:0] rx_pkt_cnt,
  output logic [15:0]          len_err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] lmin, lmax, lmin_c, lmax_c;
  logic [TO_W-1:0]      to_cnt;
  logic [15:0]          gap_cnt;
  logic in_flight, to_fire, hs_ok, tx_last_hs, gap_last, run_end, start_ok;
  logic rx_seen, rx_done, rx_len_bad;

  // Decode of events shared by the FSM and the counters; abort masks everything else.
  always_comb begin
    lmin_c     = (cfg_len_min == '0) ? LEN_WIDTH'(1) : cfg_len_min;
    lmax_c     = (cfg_len_max < lmin_c) ? lmin_c : cfg_len_max;
    in_flight  = (state == ST_SEND) || (state == ST_WAIT_RX);
    to_fire    = in_flight && !abort && (to_cnt == TO_LAST);
    hs_ok      = in_flight && !abort && !to_fire;
    tx_last_hs = hs_ok && (state == ST_SEND) && tx_axis_tvalid && tx_axis_tready && tx_axis_tlast;
    gap_last   = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, cfg_gap};
    run_end    = (cfg_pkt_num != '0) && (tx_pkt_cnt == cfg_pkt_num);
    start_ok   = (state == ST_IDLE) && start && !abort;
  end

  axis_rx_byte_accum #(
    .KEEP_W    (KEEP_W),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_rx_accum (
    .clk            (clk),
    .rst            (rst),
    .clear          (state == ST_LOAD),
    .active         (hs_ok),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tready (rx_axis_tready),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tkeep  (rx_axis_tkeep),
    .expected_len   (tx_size),
    .rx_seen        (rx_seen),
    .pkt_done       (rx_done),
    .len_mismatch   (rx_len_bad)
  );

  // Next-state logic: abort first, then timeout, then stream handshakes.
  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (start) state_n = ST_LOAD;
        ST_LOAD:    state_n = ST_SEND;
        ST_SEND: begin
          if (to_fire) state_n = ST_DONE;
          else if (tx_last_hs) state_n = (rx_seen || rx_done) ? ST_GAP : ST_WAIT_RX;
        end
        ST_WAIT_RX: begin
          if (to_fire) state_n = ST_DONE;
          else if (rx_done) state_n = ST_GAP;
        end
        ST_GAP:     if (gap_last) state_n = run_end ? ST_DONE : ST_LOAD;
        ST_DONE:    state_n = ST_IDLE;
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Registered outputs, counters and per-packet timers.
  always_ff @(posedge clk) begin
    if (rst) begin
      test_en     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      tx_size     <= '0;
      lmin        <= '0;
      lmax        <= '0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
      tx_pkt_cnt  <= '0;
      rx_pkt_cnt  <= '0;
      len_err_cnt <= '0;
    end else begin
      test_en <= (state_n == ST_SEND);
      busy    <= (state_n != ST_IDLE) && (state_n != ST_DONE);
      if (state == ST_LOAD) begin
        to_cnt  <= '0;
        gap_cnt <= '0;
      end else begin
        if (in_flight)         to_cnt  <= to_cnt + TO_W'(1);
        if (state == ST_GAP)   gap_cnt <= gap_cnt + 16'd1;
      end
      if (start_ok) begin
        tx_pkt_cnt  <= '0;
        rx_pkt_cnt  <= '0;
        len_err_cnt <= '0;
        done        <= 1'b0;
        timeout_err <= 1'b0;
        lmin        <= lmin_c;
        lmax        <= lmax_c;
        tx_size     <= lmin_c;
      end
      if (tx_last_hs) tx_pkt_cnt <= tx_pkt_cnt + CNT_WIDTH'(1);
      if (rx_done) begin
        rx_pkt_cnt <= rx_pkt_cnt + CNT_WIDTH'(1);
        if (rx_len_bad && (len_err_cnt != 16'hFFFF)) len_err_cnt <= len_err_cnt + 16'd1;
      end
      if (to_fire) timeout_err <= 1'b1;
      if ((state == ST_GAP) && (state_n == ST_LOAD)) begin
        tx_size <= (tx_size == lmax) ? lmin : tx_size + LEN_WIDTH'(1);
      end
      if ((state == ST_GAP) && (state_n == ST_DONE)) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_test_sequencer.sv
// tb/tb_axis_test_sequencer.sv - self-checking bench for axis_test_sequencer
module tb_axis_test_sequencer;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int LW = 16;
  localparam int CW = 32;
  localparam int TO = 100;

  logic          clk;
  logic          rst, start, abort;
  logic [CW-1:0] cfg_pkt_num;
  logic [LW-1:0] cfg_len_min, cfg_len_max;
  logic [15:0]   cfg_gap;
  logic          test_en;
  logic [LW-1:0] tx_size;
  logic          tx_axis_tvalid, tx_axis_tready, tx_axis_tlast;
  logic          rx_axis_tvalid, rx_axis_tready, rx_axis_tlast;
  logic [KW-1:0] rx_axis_tkeep;
  logic          busy, done, timeout_err;
  logic [CW-1:0] tx_pkt_cnt, rx_pkt_cnt;
  logic [15:0]   len_err_cnt;

  axis_test_sequencer #(
    .AXIS_DATA_WIDTH (DW),
    .LEN_WIDTH       (LW),
    .CNT_WIDTH       (CW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .cfg_pkt_num (cfg_pkt_num), .cfg_len_min (cfg_len_min),
    .cfg_len_max (cfg_len_max), .cfg_gap (cfg_gap),
    .test_en (test_en), .tx_size (tx_size),
    .tx_axis_tvalid (tx_axis_tvalid), .tx_axis_tready (tx_axis_tready),
    .tx_axis_tlast (tx_axis_tlast),
    .rx_axis_tvalid (rx_axis_tvalid), .rx_axis_tready (rx_axis_tready),
    .rx_axis_tlast (rx_axis_tlast), .rx_axis_tkeep (rx_axis_tkeep),
    .busy (busy), .done (done), .timeout_err (timeout_err),
    .tx_pkt_cnt (tx_pkt_cnt), .rx_pkt_cnt (rx_pkt_cnt), .len_err_cnt (len_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Loopback responder knobs (written by the main sequence only).
  bit lat0, rnd, drop, hold_rx;
  int flush_seq;

  // Observations owned by the responder.
  logic [KW:0] rx_q[$];
  int          sizes_q[$];
  int          gaps_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected length of packet k from the latched-bound rules.
  function automatic int exp_size(input int mn, input int mx, input int k);
    int lo, hi;
    lo = (mn < 1) ? 1 : mn;
    hi = (mx < lo) ? lo : mx;
    return lo + (k % (hi - lo + 1));
  endfunction

  // TX generator plus loopback: zero-latency mirror (lat0) or queued replay with random stalls.
  initial begin : responder
    int tx_rem, low_run, flush_seen;
    bit tx_started, prev_en, blast, vld;
    logic [KW-1:0] bkeep;
    tx_rem = 0; low_run = 0; flush_seen = 0; tx_started = 0; prev_en = 0;
    tx_axis_tvalid = 0; tx_axis_tready = 1; tx_axis_tlast = 0;
    rx_axis_tvalid = 0; rx_axis_tready = 1; rx_axis_tlast = 0; rx_axis_tkeep = '0;
    forever begin
      @(negedge clk);
      if (flush_seq != flush_seen) begin
        rx_q.delete(); sizes_q.delete(); gaps_q.delete();
        flush_seen = flush_seq;
      end
      if (test_en && !prev_en && sizes_q.size() > 0) gaps_q.push_back(low_run);
      low_run = test_en ? 0 : low_run + 1;
      prev_en = test_en;
      if (!test_en) begin
        tx_rem = 0; tx_started = 0;
      end else if (!tx_started) begin
        tx_started = 1; tx_rem = int'(tx_size); sizes_q.push_back(int'(tx_size));
      end
      tx_axis_tvalid = 0; tx_axis_tlast = 0;
      tx_axis_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      rx_axis_tvalid = 0; rx_axis_tlast = 0; rx_axis_tkeep = '0;
      rx_axis_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!lat0 && !hold_rx && rx_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
        rx_axis_tvalid = 1;
        rx_axis_tkeep  = rx_q[0][KW-1:0];
        rx_axis_tlast  = rx_q[0][KW];
        if (rx_axis_tready) void'(rx_q.pop_front());
      end
      if (tx_rem > 0) begin
        vld   = !rnd || ($urandom_range(0, 3) != 0);
        blast = (tx_rem <= KW);
        tx_axis_tvalid = vld;
        tx_axis_tlast  = blast;
        if (vld && tx_axis_tready) begin
          bkeep = '1;
          if (blast) for (int b = 0; b < KW; b++) bkeep[b] = (b < tx_rem);
          if (blast && drop) bkeep = bkeep >> 1;
          tx_rem = blast ? 0 : tx_rem - KW;
          if (lat0) begin
            rx_axis_tvalid = 1; rx_axis_tready = 1;
            rx_axis_tkeep  = bkeep; rx_axis_tlast = blast;
          end else begin
            rx_q.push_back({blast, bkeep});
          end
        end
      end
    end
  end

  task automatic start_run(input int mn, input int mx, input int num, input int gp);
    cfg_len_min = LW'(mn);
    cfg_len_max = LW'(mx);
    cfg_pkt_num = CW'(num);
    cfg_gap     = 16'(gp);
    flush_seq++;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic run_and_check(input string tag, input int mn, input int mx, input int num,
                               input int gp, input int exp_err, input bit chk_gaps, input bit poke);
    int cyc, g;
    start_run(mn, mx, num, gp);
    check({tag, "_load_busy"}, busy, 1);
    check({tag, "_load_size"}, tx_size, exp_size(mn, mx, 0));
    check({tag, "_load_en"}, test_en, 0);
    @(negedge clk);
    check({tag, "_send_en"}, test_en, 1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      start = poke && (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    start = 0;
    check({tag, "_finished"}, busy, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_tx_cnt"}, tx_pkt_cnt, num);
    check({tag, "_rx_cnt"}, rx_pkt_cnt, num);
    check({tag, "_len_err"}, len_err_cnt, exp_err);
    check({tag, "_npkts"}, sizes_q.size(), num);
    for (int k = 0; k < sizes_q.size() && k < num; k++)
      check($sformatf("%s_size%0d", tag, k), sizes_q[k], exp_size(mn, mx, k));
    if (chk_gaps) begin
      g = ((gp < 1) ? 1 : gp) + 1;
      check({tag, "_ngaps"}, gaps_q.size(), num - 1);
      for (int k = 0; k < gaps_q.size(); k++)
        check($sformatf("%s_gap%0d", tag, k), gaps_q[k], g);
    end
    @(negedge clk);
    check({tag, "_done_holds"}, done, 1);
    check({tag, "_idle"}, busy, 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, observed busy=%0d expected 0", busy);
    $fatal(1, "time limit");
  end

  initial begin : main
    int cyc, mn, mx, num, gp;
    rst = 1; start = 0; abort = 0;
    cfg_pkt_num = '0; cfg_len_min = '0; cfg_len_max = '0; cfg_gap = '0;
    lat0 = 0; rnd = 0; drop = 0; hold_rx = 0; flush_seq = 0;
    repeat (3) @(negedge clk);
    check("rst_test_en", test_en, 0);
    check("rst_tx_size", tx_size, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_tx_cnt", tx_pkt_cnt, 0);
    check("rst_rx_cnt", rx_pkt_cnt, 0);
    check("rst_len_err", len_err_cnt, 0);
    rst = 0;
    @(negedge clk);

    // Ideal loopback: RX tlast coincides with TX tlast, so WAIT_RX is skipped.
    lat0 = 1;
    run_and_check("sweep", 60, 62, 5, 4, 0, 1, 1);
    run_and_check("minlen", 0, 0, 3, 0, 0, 1, 0);

    // Queued loopback with random stalls; one byte dropped on each last beat.
    lat0 = 0; rnd = 1; drop = 1;
    run_and_check("drop", 64, 64, 3, 1, 3, 0, 0);
    drop = 0;
    for (int r = 0; r < 3; r++) begin
      mn  = $urandom_range(0, 24);
      mx  = $urandom_range(0, 40);
      num = $urandom_range(1, 6);
      gp  = $urandom_range(0, 3);
      run_and_check($sformatf("rand%0d", r), mn, mx, num, gp, 0, 0, 0);
    end

    // RX never answers: WAIT_RX must time out.
    rnd = 0; hold_rx = 1;
    start_run(8, 8, 1, 0);
    cyc = 0;
    while (!test_en && cyc < 10) begin @(negedge clk); cyc++; end
    check("to_send_entered", test_en, 1);
    cyc = 0;
    while (busy && cyc < 200) begin @(negedge clk); cyc++; end
    check("to_latency_ok", (cyc >= TO - 1) && (cyc <= TO + 2), 1);
    check("to_timeout_err", timeout_err, 1);
    check("to_done", done, 0);
    check("to_test_en", test_en, 0);
    check("to_busy", busy, 0);
    check("to_tx_cnt", tx_pkt_cnt, 1);
    check("to_rx_cnt", rx_pkt_cnt, 0);
    @(negedge clk);
    check("to_err_holds", timeout_err, 1);
    hold_rx = 0; flush_seq++;
    repeat (2) @(negedge clk);

    // Abort during SEND of packet 2 in continuous mode.
    lat0 = 1;
    start_run(16, 16, 0, 2);
    cyc = 0;
    while (!(test_en && tx_pkt_cnt == 1) && cyc < 500) begin @(negedge clk); cyc++; end
    check("ab_reached_pkt2", test_en && (tx_pkt_cnt == 1), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("ab_busy", busy, 0);
    check("ab_test_en", test_en, 0);
    check("ab_tx_cnt", tx_pkt_cnt, 1);
    check("ab_rx_cnt", rx_pkt_cnt, 1);
    check("ab_done", done, 0);
    @(negedge clk);
    check("ab_stays_idle", busy, 0);
    check("ab_tx_cnt_holds", tx_pkt_cnt, 1);
    flush_seq++;
    repeat (2) @(negedge clk);

    // Reset in the middle of a continuous run.
    start_run(10, 10, 0, 0);
    repeat (15) @(negedge clk);
    check("mr_running", busy, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mr_busy", busy, 0);
    check("mr_test_en", test_en, 0);
    check("mr_tx_cnt", tx_pkt_cnt, 0);
    check("mr_rx_cnt", rx_pkt_cnt, 0);
    check("mr_tx_size", tx_size, 0);
    flush_seq++;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
